rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one 8-way resource (one-hot select line per requester) between eight requesters. The arbiter owns a 3-bit grant index that drives the 3-to-8 decoder's select inputs, and it also supplies the registered one-hot grant and valid flag. A bounded hold timer keeps any requester from monopolising the resource.

---
 rtl/rr_arbiter8_pkg.sv | 15 +
 rtl/rr_arbiter8_if.sv | 23 ++
 rtl/rr_arbiter8_pick.sv | 30 +++
 rtl/rr_arbiter8.sv | 83 ++++++++
 tb/tb_rr_arbiter8.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared types and sizes for the 8-way round-robin arbiter.
// Contents: FSM state encoding, requester count and grant-index width.
// Imported by the interface, the pick logic and the arbiter top.
package rr_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight requesters and the arbiter.
// Ports: none; signals en, req (requester side) and gnt, gnt_idx, gnt_vld, timeout (arbiter side).
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/rr_arbiter8_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr.
// Ports: req[7:0], ptr[2:0] in; pick_idx[2:0], pick_vld out.
// Zero latency; pick_idx is don't-care when pick_vld is low.
module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     offset;

  // Rotating right by ptr puts requester ptr at bit 0, so the lowest set
  // bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IDX_W'(i);
    end
    pick_vld = |req;
    pick_idx = offset + ptr;  // wraps mod 8 by width
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for eight requesters with a bounded hold timer.
// Ports: sys_clk, sys_rst_n (async, active low), bus (slave: en/req in; gnt/gnt_idx/gnt_vld/timeout out).
// One cycle req->gnt; each grant is followed by one GAP and one IDLE cycle; outputs all registered.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter logic [15:0] HOLD_MAX = 16'd1000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  rr_arbiter8_if.slave   bus
);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [15:0]        hold_cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_vld_q;
  logic               timeout_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               own_req;

  rr_pick u_pick (
    .req      (bus.req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign own_req = bus.req[gnt_idx_q];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.en && pick_vld) begin
            state     <= ST_GRANT;
            gnt_idx_q <= pick_idx;
            gnt_q     <= NUM_REQ'(1) << pick_idx;
            gnt_vld_q <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (!own_req || hold_cnt == HOLD_MAX - 16'd1) begin
            state     <= ST_GAP;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            ptr       <= gnt_idx_q + IDX_W'(1);
            // A release on the final cycle takes precedence: no timeout then.
            timeout_q <= own_req;
          end else if (hold_cnt != 16'hFFFF) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: randomized and directed checks of rr_arbiter8 against a behavioural model.
// Ports: none; instantiates rr_arbiter8_if and rr_arbiter8 with HOLD_MAX = 4.
// Outputs compared 1 ns after every rising edge and during asynchronous reset.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.HOLD_MAX(16'd4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Model: who owns the resource, for how many cycles, whether we sit in the
  // dead cycle after a grant, and where the next search starts.
  int m_owner;
  int m_len;
  int m_gap;
  int m_ptr;
  int m_last;
  int m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_last  = 0;
    m_to    = 0;
  endtask

  task automatic model_end(input int timed_out);
    m_ptr   = (m_owner + 1) % 8;
    m_owner = -1;
    m_gap   = 1;
    m_to    = timed_out;
  endtask

  task automatic model_step();
    int k;
    m_to = 0;
    if (m_owner >= 0) begin
      if (!bus.req[m_owner]) model_end(0);
      else if (m_len == HOLD) model_end(1);
      else m_len++;
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (bus.en && bus.req != 8'h00) begin
      for (int j = 0; j < 8; j++) begin
        k = (m_ptr + j) % 8;
        if (bus.req[k]) begin
          m_owner = k;
          m_last  = k;
          m_len   = 1;
          break;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [7:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_last));
    chk("gnt_vld", 32'(bus.gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called 1 ns after an edge: pull reset low mid-cycle, confirm outputs drop
  // before any edge, then release on the falling edge.
  task automatic do_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  int         grant_idx_q[$];
  int         grant_len_q[$];
  int         to_cnt;
  logic       prev_vld;
  logic [7:0] rnd_req;

  initial begin
    bus.en  = 1'b1;
    bus.req = 8'h00;
    model_reset();
    @(negedge sys_clk);
    #1;
    compare_outputs();
    sys_rst_n = 1'b1;

    // Idle with no requests.
    ticks(10);

    // Two masters held high: alternate 2,5,2,... with timeouts.
    bus.req  = 8'h24;
    prev_vld = 1'b0;
    to_cnt   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.gnt_vld && !prev_vld) begin
        grant_idx_q.push_back(int'(bus.gnt_idx));
        grant_len_q.push_back(0);
      end
      if (bus.gnt_vld) grant_len_q[grant_len_q.size() - 1]++;
      if (bus.timeout) to_cnt++;
      prev_vld = bus.gnt_vld;
    end
    chk("alt_grants", 32'(grant_idx_q.size()), 32'd5);
    chk("alt_timeouts", 32'(to_cnt), 32'd5);
    for (int i = 0; i < grant_idx_q.size(); i++) begin
      chk("alt_idx", 32'(grant_idx_q[i]), (i % 2 == 0) ? 32'd2 : 32'd5);
      chk("alt_len", 32'(grant_len_q[i]), 32'd4);
    end
    bus.req = 8'h00;
    ticks(3);

    // Wrap: requester 0 releases after 2 cycles, then 7 is served.
    do_reset();
    bus.req = 8'h81;
    ticks(2);
    chk("wrap_first", 32'(bus.gnt_idx), 32'd0);
    bus.req = 8'h80;
    tick();
    chk("wrap_no_to", 32'(bus.timeout), 32'd0);
    ticks(2);
    chk("wrap_second", 32'(bus.gnt), 32'h80);
    bus.req = 8'h00;
    ticks(3);

    // Enable dropped during grant to 3: grant finishes, nothing new until en.
    do_reset();
    bus.req = 8'h04;
    tick();
    bus.req = 8'h08;
    ticks(3);
    chk("en_grant3", 32'(bus.gnt_idx), 32'd3);
    bus.req = 8'h0C;
    bus.en  = 1'b0;
    ticks(10);
    chk("en_held_idle", 32'(bus.gnt_vld), 32'd0);
    bus.en = 1'b1;
    tick();
    chk("en_grant2", 32'(bus.gnt), 32'h04);
    bus.req = 8'h00;
    ticks(3);

    // Asynchronous reset in the middle of a grant to 6.
    bus.req = 8'h40;
    ticks(2);
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h40);
    bus.req = 8'hFF;
    do_reset();
    tick();
    chk("post_rst_idx", 32'(bus.gnt_idx), 32'd0);
    bus.req = 8'h00;
    ticks(3);

    // Release on the last allowed cycle: no timeout pulse.
    bus.req = 8'h01;
    ticks(4);
    bus.req = 8'h00;
    tick();
    chk("last_cycle_rel_to", 32'(bus.timeout), 32'd0);
    chk("last_cycle_rel_vld", 32'(bus.gnt_vld), 32'd0);
    ticks(2);

    // Random traffic with occasional enable drops and resets.
    rnd_req = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd_req = 8'($urandom);
        if ($urandom_range(0, 2) == 0) rnd_req = rnd_req & 8'($urandom);
      end
      bus.req = rnd_req;
      bus.en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
